// File: rtl/shift_ex_stage_pkg.sv
// Shared definitions for the shift execute stage: funct3 encodings, decoded S1 record, decode helper.
package shift_ex_stage_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SR  = 3'b101;

  typedef struct packed {
    logic               left;
    logic               arith;
    logic               illegal;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    rs1;
    logic [4:0]         rd;
  } s1_t;

  // SLL with bit 30 set is not a legal encoding, so only plain funct3 match counts as legal there.
  function automatic s1_t decode(
    input logic [2:0]         funct3,
    input logic               funct7_5,
    input logic               is_imm,
    input logic [XLEN-1:0]    rs1,
    input logic [XLEN-1:0]    rs2,
    input logic [SHAMT_W-1:0] imm_shamt,
    input logic [4:0]         rd
  );
    s1_t d;
    d.left    = (funct3 == FUNCT3_SLL);
    d.arith   = (funct3 == FUNCT3_SR) && funct7_5;
    d.illegal = !((funct3 == FUNCT3_SLL) && !funct7_5) && (funct3 != FUNCT3_SR);
    d.shamt   = is_imm ? imm_shamt : rs2[SHAMT_W-1:0];
    d.rs1     = rs1;
    d.rd      = rd;
    return d;
  endfunction

endpackage

// File: rtl/shift_ex_stage_if.sv
// Upstream op / downstream result handshake bundle for the shift execute stage.
interface shift_ex_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic        in_is_imm;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_imm_shamt;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  modport master (
    output in_valid, in_funct3, in_funct7_5, in_is_imm, in_rs1, in_rs2, in_imm_shamt, in_rd,
    output out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_funct3, in_funct7_5, in_is_imm, in_rs1, in_rs2, in_imm_shamt, in_rd,
    input  out_ready,
    output in_ready, out_valid, out_result, out_rd, out_illegal
  );

endinterface

// File: rtl/barrel_shifter_32.sv
// Combinational 32-bit log shifter; left shifts reuse the right-shift network by bit-reversing in and out.
module barrel_shifter_32 (
  input  logic [31:0] data,
  input  logic [4:0]  shamt,
  input  logic        left,
  input  logic        arith,
  output logic [31:0] result
);

  logic [31:0] pre;
  logic [31:0] post;
  logic        fill;

  assign fill = arith & ~left & data[31];

  for (genvar gi = 0; gi < 32; gi++) begin : g_rev
    assign pre[gi]    = left ? data[31-gi] : data[gi];
    assign result[gi] = left ? post[31-gi] : post[gi];
  end

  always_comb begin
    post = pre;
    for (int i = 0; i < 5; i++) begin
      if (shamt[i]) begin
        post = (post >> (1 << i)) | ({32{fill}} & ~(32'hFFFF_FFFF >> (1 << i)));
      end
    end
  end

endmodule

// File: rtl/shift_ex_stage.sv
// Two-stage RISC-V shift execute unit: S1 holds decoded operands, S2 holds the result.
module shift_ex_stage
  import shift_ex_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  shift_ex_stage_if.slave  bus
);

  logic            s1_valid;
  s1_t             s1;
  logic            s2_valid;
  logic [XLEN-1:0] s2_result;
  logic [4:0]      s2_rd;
  logic            s2_illegal;
  logic            s2_free;
  logic            in_ready;
  logic [XLEN-1:0] shift_result;

  // S2 can take a new value when empty or when its current result leaves this cycle.
  assign s2_free  = !s2_valid || bus.out_ready;
  assign in_ready = !flush && (!s1_valid || s2_free);

  barrel_shifter_32 u_shifter (
    .data   (s1.rs1),
    .shamt  (s1.shamt),
    .left   (s1.left),
    .arith  (s1.arith),
    .result (shift_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1 <= decode(bus.in_funct3, bus.in_funct7_5, bus.in_is_imm, bus.in_rs1,
                     bus.in_rs2, bus.in_imm_shamt, bus.in_rd);
      end
    end
  end

  // Result fields are zeroed whenever S2 goes empty so out_result reads 0 while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_rd      <= '0;
      s2_illegal <= 1'b0;
    end else if (flush) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_rd      <= '0;
      s2_illegal <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result  <= s1.illegal ? '0 : shift_result;
        s2_rd      <= s1.rd;
        s2_illegal <= s1.illegal;
      end else begin
        s2_result  <= '0;
        s2_rd      <= '0;
        s2_illegal <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = s2_valid;
  assign bus.out_result  = s2_result;
  assign bus.out_rd      = s2_rd;
  assign bus.out_illegal = s2_illegal;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Scoreboard bench for shift_ex_stage: ops push expected results, a negedge monitor pops and compares.
module tb_shift_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  shift_ex_stage_if bus ();

  shift_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   outputs_seen = 0;

  function automatic exp_t model(input logic [2:0] f3, input logic f7, input logic imm,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [4:0] ish, input logic [4:0] rd);
    exp_t               e;
    logic [4:0]         sh;
    logic signed [31:0] srs;
    sh    = imm ? ish : rs2[4:0];
    srs   = rs1;
    e.rd  = rd;
    e.ill = 1'b1;
    e.res = 32'h0;
    if (f3 == 3'b001 && !f7) begin
      e.ill = 1'b0;
      e.res = rs1 << sh;
    end else if (f3 == 3'b101) begin
      e.ill = 1'b0;
      if (f7) begin
        srs   = srs >>> sh;
        e.res = srs;
      end else begin
        e.res = rs1 >> sh;
      end
    end
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!bus.out_valid) begin
          vectors++;
          if (bus.out_result !== 32'h0) begin
            miscompares++;
            $display("FAIL idle_result: got %h expected 00000000", bus.out_result);
          end
        end else if (bus.out_ready) begin
          outputs_seen++;
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: got res=%h rd=%0d with empty scoreboard",
                     bus.out_result, bus.out_rd);
          end else begin
            e = sb.pop_front();
            if ({bus.out_result, bus.out_rd, bus.out_illegal} !== {e.res, e.rd, e.ill}) begin
              miscompares++;
              $display("FAIL result: got res=%h rd=%0d ill=%b expected res=%h rd=%0d ill=%b",
                       bus.out_result, bus.out_rd, bus.out_illegal, e.res, e.rd, e.ill);
            end
          end
        end
      end
    end
  endtask

  // Called and returns 1ns after a rising edge; holds the op until it is accepted.
  task automatic send(input logic [2:0] f3, input logic f7, input logic imm,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [4:0] ish, input logic [4:0] rd);
    bus.in_valid     = 1'b1;
    bus.in_funct3    = f3;
    bus.in_funct7_5  = f7;
    bus.in_is_imm    = imm;
    bus.in_rs1       = rs1;
    bus.in_rs2       = rs2;
    bus.in_imm_shamt = ish;
    bus.in_rd        = rd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(f3, f7, imm, rs1, rs2, ish, rd));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected 1");
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({bus.out_valid, bus.out_result, bus.out_rd, bus.out_illegal} !== 39'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b res=%h rd=%0d ill=%b expected all 0",
               bus.out_valid, bus.out_result, bus.out_rd, bus.out_illegal);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0",
               bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_slli();
    send(3'b001, 1'b0, 1'b1, 32'h0000_0001, 32'h0, 5'd31, 5'd5);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL slli_latency1: got out_valid=%b expected 0", bus.out_valid);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h8000_0000 || bus.out_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL slli_result: got v=%b res=%h ill=%b expected 1 80000000 0",
               bus.out_valid, bus.out_result, bus.out_illegal);
    end
    wait_drain();
  endtask

  task automatic test_sra();
    send(3'b101, 1'b1, 1'b0, 32'h8000_00F0, 32'hFFFF_FFE4, 5'd0, 5'd9);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hF800_000F) begin
      miscompares++;
      $display("FAIL sra_result: got v=%b res=%h expected 1 f800000f", bus.out_valid, bus.out_result);
    end
    wait_drain();
    send(3'b101, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd1);
    send(3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 5'd31, 5'd2);
    send(3'b001, 1'b0, 1'b0, 32'h1234_5678, 32'hFFFF_FFE0, 5'd7, 5'd3);
    send(3'b101, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_001F, 5'd0, 5'd4);
    wait_drain();
  endtask

  task automatic test_illegal();
    send(3'b001, 1'b1, 1'b0, 32'h0000_FFFF, 32'h3, 5'd0, 5'd17);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 || bus.out_result !== 32'h0 ||
        bus.out_rd !== 5'd17) begin
      miscompares++;
      $display("FAIL illegal_sll: got v=%b ill=%b res=%h rd=%0d expected 1 1 00000000 17",
               bus.out_valid, bus.out_illegal, bus.out_result, bus.out_rd);
    end
    wait_drain();
    send(3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 5'd3, 5'd20);
    send(3'b111, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd0, 5'd21);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int          seen0;
    logic [31:0] held;
    seen0 = outputs_seen;
    bus.out_ready = 1'b0;
    fork
      begin
        send(3'b101, 1'b0, 1'b1, 32'hF0F0_0000, 32'h0, 5'd4, 5'd10);
        send(3'b101, 1'b0, 1'b1, 32'h8000_0001, 32'h0, 5'd1, 5'd11);
        send(3'b101, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd31, 5'd0, 5'd12);
      end
      begin
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
        held = bus.out_result;
        vectors++;
        if (held !== 32'h0F0F_0000) begin
          miscompares++;
          $display("FAIL b2b_first: got %h expected 0f0f0000", held);
        end
        for (int k = 0; k < 3; k++) begin
          vectors++;
          if (bus.out_valid !== 1'b1 || bus.out_result !== held || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_stall: got v=%b res=%h in_ready=%b expected 1 %h 0",
                     bus.out_valid, bus.out_result, bus.in_ready, held);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    vectors++;
    if (outputs_seen - seen0 !== 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d outputs expected 3", outputs_seen - seen0);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    send(3'b001, 1'b0, 1'b1, 32'h0000_0003, 32'h0, 5'd2, 5'd6);
    send(3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 5'd2, 5'd7);
    bus.in_valid     = 1'b1;
    bus.in_funct3    = 3'b001;
    bus.in_funct7_5  = 1'b0;
    bus.in_is_imm    = 1'b1;
    bus.in_rs1       = 32'h0000_00FF;
    bus.in_imm_shamt = 5'd8;
    bus.in_rd        = 5'd8;
    flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_no_capture: got out_valid=%b expected 0", bus.out_valid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    send(3'b001, 1'b0, 1'b1, 32'h0000_0001, 32'h0, 5'd4, 5'd13);
    send(3'b101, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0, 5'd8, 5'd14);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.out_valid, bus.out_result, bus.out_rd, bus.out_illegal} !== 39'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%b res=%h rd=%0d ill=%b expected all 0",
               bus.out_valid, bus.out_result, bus.out_rd, bus.out_illegal);
    end
    sb.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ghost: got out_valid=%b expected 0", bus.out_valid);
      end
    end
    @(posedge clk);
    #1;
    send(3'b101, 1'b1, 1'b1, 32'hC000_0000, 32'h0, 5'd1, 5'd15);
    wait_drain();
  endtask

  task automatic test_random();
    bit          done;
    logic [2:0]  f3;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          if ($urandom_range(0, 3) != 0) f3 = ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b101;
          else f3 = 3'($urandom_range(0, 7));
          send(f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_funct3    = 3'b000;
    bus.in_funct7_5  = 1'b0;
    bus.in_is_imm    = 1'b0;
    bus.in_rs1       = 32'h0;
    bus.in_rs2       = 32'h0;
    bus.in_imm_shamt = 5'd0;
    bus.in_rd        = 5'd0;
    bus.out_ready    = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_slli();
    test_sra();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
